// File: rtl/mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between the fetch port and the
// load/store port, one transaction at a time, data first with a fetch anti-starvation guard.
module mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CNT_W  = $clog2(MEM_LAT + 1);
    localparam int STRK_W = $clog2(STARVE_MAX + 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [STRK_W-1:0] streak;
    logic              own_d;
    logic              starved;
    logic              grant_d;
    logic              grant_i;

    function automatic logic [STRK_W-1:0] sat_inc(input logic [STRK_W-1:0] v);
        return (v == STRK_W'(STARVE_MAX)) ? v : v + 1'b1;
    endfunction

    // Data has priority unless fetch has waited through STARVE_MAX data grants.
    always_comb begin
        starved = (streak == STRK_W'(STARVE_MAX));
        grant_d = d_req & ~(if_req & starved);
        grant_i = if_req & ~grant_d;
    end

    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            streak    <= '0;
            own_d     <= 1'b0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;

            case (state)
                S_IDLE: begin
                    // The mem_* registers double as the winner's latched request
                    // for the single ISSUE cycle that follows.
                    if (grant_d || grant_i) begin
                        own_d     <= grant_d;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_d & d_we;
                        mem_addr  <= grant_d ? d_addr : if_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        state     <= S_ISSUE;
                        if (grant_i)
                            streak <= '0;
                        else if (if_req)
                            streak <= sat_inc(streak);
                    end
                end

                S_ISSUE: begin
                    cnt   <= CNT_W'(MEM_LAT);
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt <= '0;
                        if (own_d) begin
                            d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port and its data (load/store) port. It sits between the Datapath's IF and MEM stages and the unified memory. It serialises accesses through a small FSM, prioritises data accesses with an anti-starvation guard for fetch, and returns per-port ready pulses plus stall signals for the pipeline registers.

## Interface
- DATA_W, 32: data width.
- ADDR_W, 9: word address width, matching the PC width.
- MEM_LAT, 1: memory read latency in cycles, ≥1. mem_rdata is valid MEM_LAT cycles after the mem_en cycle.
- STARVE_MAX, 4: maximum consecutive data grants while if_req is pending, ≥1.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request; held with if_addr stable until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_ready  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_W  fetched word; valid while if_ready=1.
- if_stall  out  1  if_req & ~if_ready (combinational).
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle completion pulse for data.
- d_rdata  out  DATA_W  load data; valid while d_ready=1. Value is unspecified for stores.
- d_stall  out  1  d_req & ~d_ready (combinational).
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP. Only one transaction is outstanding at a time.
- IDLE: samples the requests.
  - If neither request is present, stay in IDLE.
  - If any request is present, latch the winner (owner bit, we, addr, wdata) and go to ISSUE.
- Arbitration:
  - d_req alone → data wins.
  - if_req alone → fetch wins.
  - Both present → data wins, unless streak==STARVE_MAX, in which case fetch wins.
- streak counter:
  - Increments on a data grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on any fetch grant.
  - Is unchanged on a data grant made while if_req=0.
- ISSUE: drives mem_en=1 and mem_we/mem_addr/mem_wdata from the latched values, then goes to WAIT. cnt loads MEM_LAT.
- WAIT: lasts exactly MEM_LAT cycles; cnt decrements each cycle. On the last WAIT cycle (cnt==1), capture mem_rdata into the owner's rdata register and go to RESP.
- RESP: pulse the owner's ready for one cycle, then go to IDLE. The arbiter does not re-arbitrate in RESP, so a requester may keep req high for a back-to-back access.
- Request deassertion after grant is a protocol violation. The arbiter ignores it, completes the transaction and still pulses ready.
- mem_en, mem_we, mem_addr and mem_wdata are registered. They are 0 outside ISSUE.
- if_rdata and d_rdata hold their last captured value until the next capture for the same port.
- reset (any state, including mid-WAIT):
  - Next state is IDLE; streak, cnt, latches and rdata registers clear to 0.
  - All registered outputs go to 0. The in-flight transaction is abandoned and no ready pulse is issued.

## Timing
- Reset values: if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Stalls are 0 after reset unless a req is high.
- Transaction timeline, with the request seen in IDLE at cycle C0:
  - ISSUE (mem_en=1) in C1.
  - WAIT in C2..C(1+MEM_LAT).
  - ready pulse in C(2+MEM_LAT).
  - Next arbitration in C(3+MEM_LAT).
- Latency is MEM_LAT+2 cycles. Throughput is one transaction per MEM_LAT+3 cycles.
- mem_rdata is sampled only at the edge ending cycle C(1+MEM_LAT).
- Reset asserted in the same cycle as a request takes priority: the FSM stays in IDLE and no grant is made.

## Test plan
- Reset: hold reset 2 cycles with both reqs high → all registered outputs 0 and no mem_en. After release, first mem_en in the 2nd cycle after reset deasserts.
- Single fetch, MEM_LAT=1: if_req and if_addr=0x010 at C0 → mem_en=1, mem_we=0, mem_addr=0x010 in C1; memory returns 0x00500093 in C2 → if_ready=1, if_rdata=0x00500093 in C3 only; if_stall=1 in C0–C2.
- Store: d_req, d_we=1, d_addr=0x020, d_wdata=0xDEADBEEF at C0 → mem_en=1, mem_we=1, mem_addr=0x020, mem_wdata=0xDEADBEEF in C1; d_ready in C3.
- Simultaneous requests, MEM_LAT=1: both reqs at C0 → data issues in C1 with d_ready in C3; fetch issues in C5 with if_ready in C7.
- Starvation, STARVE_MAX=4: d_req and if_req held continuously → grant order D,D,D,D,I,D,D,D,D,I.
- Reset mid-WAIT, MEM_LAT=3: assert reset in C3 → no ready pulse in C5, mem outputs 0. A new if_req after reset completes with the normal MEM_LAT+2 latency.
